// File: rtl/npu_chain_sequencer_pkg.sv
// Shared state encoding and default widths for the NPU chain sequencer.
package npu_chain_sequencer_pkg;

  localparam int unsigned DefOrfAwidth  = 4;
  localparam int unsigned DefDramAwidth = 10;
  localparam int unsigned DefTimeout    = 1023;

  typedef enum logic [2:0] {
    StIdle,
    StMvuRst,
    StMvuRun,
    StDrain,
    StFlush,
    StFin
  } seq_state_e;

endpackage

// File: rtl/npu_chain_sequencer_seq_watchdog.sv
// Wait-state watchdog: counts while enabled, clears on demand, raises a sticky error at TIMEOUT.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o,
  output logic err_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign expired_o = count_en_i && (cnt_q == CntMax);
  assign err_o     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (clear_i || !count_en_i) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (expired_o) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_chain_sequencer.sv
// Owns one matrix-vector job: MVU reset/start, ORF drain into the MFU, and result writeback to DRAM.
module npu_chain_sequencer
  import npu_chain_sequencer_pkg::*;
#(
  parameter int unsigned ORF_AWIDTH  = DefOrfAwidth,
  parameter int unsigned DRAM_AWIDTH = DefDramAwidth,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ORF_AWIDTH:0]    cmd_rows,
  input  logic [DRAM_AWIDTH-1:0] cmd_base,
  input  logic                   cmd_bypass,
  output logic                   reset_mvu,
  output logic                   start_mvu,
  input  logic                   done_mvm,
  output logic [ORF_AWIDTH-1:0]  orf_rd_addr,
  output logic                   in_data_available,
  input  logic                   out_data_available,
  output logic                   wr_sel_bypass,
  output logic [DRAM_AWIDTH-1:0] dram_addr,
  output logic                   dram_write_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [ORF_AWIDTH:0] RowOne = 1;

  seq_state_e state_q, state_d;

  logic [ORF_AWIDTH:0]    rows_q;
  logic [DRAM_AWIDTH-1:0] base_q;
  logic                   bypass_q;
  logic [ORF_AWIDTH:0]    ic_q;
  logic [ORF_AWIDTH:0]    wc_q;
  logic                   byp_wr_q;

  logic [ORF_AWIDTH:0] ic_inc;
  logic                in_wb_window;
  logic                mfu_wr;
  logic                wr_en;
  logic                wd_clear;
  logic                wd_count_en;
  logic                wd_expired;
  logic                wd_err;

  assign ic_inc       = ic_q + RowOne;
  assign in_wb_window = (state_q == StDrain) || (state_q == StFlush);
  // MFU results past the last expected row are dropped rather than written.
  assign mfu_wr       = in_wb_window && !bypass_q && out_data_available && (wc_q != rows_q);
  assign wr_en        = bypass_q ? byp_wr_q : mfu_wr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = (cmd_rows == '0) ? StFin : StMvuRst;
        end
      end
      StMvuRst: state_d = StMvuRun;
      StMvuRun: begin
        if (done_mvm) begin
          state_d = StDrain;
        end else if (wd_expired) begin
          state_d = StFin;
        end
      end
      StDrain: begin
        if (ic_inc == rows_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (wc_q == rows_q || wd_expired) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready         = (state_q == StIdle);
    busy              = (state_q != StIdle);
    reset_mvu         = (state_q == StMvuRst);
    start_mvu         = (state_q == StMvuRun);
    done              = (state_q == StFin);
    in_data_available = (state_q == StDrain) && !bypass_q;
    orf_rd_addr       = '0;
    if (state_q == StDrain) begin
      orf_rd_addr = ic_q[ORF_AWIDTH-1:0];
    end
    wr_sel_bypass     = bypass_q;
    err               = wd_err;
    dram_write_enable = wr_en;
    dram_addr         = '0;
    if (wr_en) begin
      dram_addr = base_q + DRAM_AWIDTH'(wc_q);
    end
  end

  assign wd_count_en = (state_q == StMvuRun) || (state_q == StFlush);
  assign wd_clear    = (state_d != state_q) || wr_en;

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .count_en_i(wd_count_en),
    .expired_o (wd_expired),
    .err_o     (wd_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rows_q   <= '0;
      base_q   <= '0;
      bypass_q <= 1'b0;
      ic_q     <= '0;
      wc_q     <= '0;
      byp_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      // Bypass writes trail each ORF issue by the one-cycle ORF read latency.
      byp_wr_q <= (state_q == StDrain) && bypass_q;
      if (state_q == StIdle && cmd_valid) begin
        rows_q   <= cmd_rows;
        base_q   <= cmd_base;
        bypass_q <= cmd_bypass;
        ic_q     <= '0;
        wc_q     <= '0;
      end else begin
        if (state_q == StDrain) begin
          ic_q <= ic_inc;
        end
        if (wr_en) begin
          wc_q <= wc_q + RowOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_npu_chain_sequencer.sv
// Directed self-checking bench for npu_chain_sequencer with a latency-3 MFU model.
module tb_npu_chain_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_rows;
  logic [9:0] cmd_base;
  logic       cmd_bypass;
  logic       reset_mvu;
  logic       start_mvu;
  logic       done_mvm;
  logic [3:0] orf_rd_addr;
  logic       in_data_available;
  logic       out_data_available;
  logic       wr_sel_bypass;
  logic [9:0] dram_addr;
  logic       dram_write_enable;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  npu_chain_sequencer #(
    .ORF_AWIDTH (4),
    .DRAM_AWIDTH(10),
    .TIMEOUT    (1023)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_rows          (cmd_rows),
    .cmd_base          (cmd_base),
    .cmd_bypass        (cmd_bypass),
    .reset_mvu         (reset_mvu),
    .start_mvu         (start_mvu),
    .done_mvm          (done_mvm),
    .orf_rd_addr       (orf_rd_addr),
    .in_data_available (in_data_available),
    .out_data_available(out_data_available),
    .wr_sel_bypass     (wr_sel_bypass),
    .dram_addr         (dram_addr),
    .dram_write_enable (dram_write_enable),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cmd_ready, busy, reset_mvu, start_mvu, in_data_available, dram_write_enable, done, err, wr_sel}
  function automatic logic [8:0] outv();
    return {cmd_ready, busy, reset_mvu, start_mvu, in_data_available, dram_write_enable, done, err,
            wr_sel_bypass};
  endfunction

  // Accepts one job, releases done_mvm mvu_dly cycles after start, then checks the drain/writeback.
  task automatic run_job(input int rows, input int base, input bit byp, input int mvu_dly,
                         input int extra_c);
    int         nwr;
    int         exp_done;
    bit   [3:0] sr;
    logic       exp_we;
    logic [9:0] exp_addr;
    nwr        = 0;
    sr         = '0;
    exp_done   = byp ? rows + 3 : rows + 5;
    cmd_valid  = 1'b1;
    cmd_rows   = rows[4:0];
    cmd_base   = base[9:0];
    cmd_bypass = byp;
    #1;
    chk("accept_ready", cmd_ready, 1);
    next();
    cmd_valid = 1'b0;
    chk("reset_mvu_pulse", reset_mvu, 1);
    chk("busy_after_accept", busy, 1);
    next();
    chk("start_mvu_high", start_mvu, 1);
    chk("reset_mvu_single", reset_mvu, 0);
    repeat (mvu_dly) next();
    done_mvm = 1'b1;
    #1;
    chk("start_held_at_done_mvm", start_mvu, 1);
    next();
    done_mvm = 1'b0;
    for (int c = 1; c <= rows + 7; c++) begin
      out_data_available = sr[2] | (c == extra_c);
      #1;
      exp_we = byp ? (c >= 2 && c <= rows + 1) : (out_data_available && nwr < rows);
      chk("in_data_available", in_data_available, (!byp && c <= rows));
      if (c <= rows) chk("orf_rd_addr", orf_rd_addr, c - 1);
      chk("start_mvu_low", start_mvu, 0);
      chk("dram_write_enable", dram_write_enable, exp_we);
      if (exp_we) begin
        exp_addr = 10'(base + nwr);
        chk("dram_addr", dram_addr, exp_addr);
      end
      chk("done_timing", done, (c == exp_done));
      if (c <= rows + 1) chk("wr_sel_bypass", wr_sel_bypass, byp);
      if (dram_write_enable) nwr++;
      sr = {sr[2:0], in_data_available};
      next();
    end
    out_data_available = 1'b0;
    chk("write_count", nwr, rows);
    chk("ready_after_job", cmd_ready, 1);
  endtask

  int k;
  bit got;

  initial begin
    reset              = 1'b1;
    cmd_valid          = 1'b0;
    cmd_rows           = '0;
    cmd_base           = '0;
    cmd_bypass         = 1'b0;
    done_mvm           = 1'b0;
    out_data_available = 1'b0;
    next();
    next();
    chk("reset_outputs", outv(), 9'b1_0000_0000);
    chk("reset_orf_addr", orf_rd_addr, 0);
    chk("reset_dram_addr", dram_addr, 0);
    reset = 1'b0;
    next();

    // Normal MFU job: rows=4, base 0x100, done_mvm 20 cycles after start.
    run_job(4, 'h100, 1'b0, 20, 0);

    // Bypass job: 16 rows straight from the ORF.
    run_job(16, 'h020, 1'b1, 5, 0);

    // Zero rows: straight to FIN, no MVU activity, no writes.
    cmd_valid  = 1'b1;
    cmd_rows   = 5'd0;
    cmd_base   = 10'h055;
    cmd_bypass = 1'b0;
    #1;
    chk("zero_accept_ready", cmd_ready, 1);
    next();
    cmd_valid = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_no_reset_mvu", reset_mvu, 0);
    chk("zero_no_start", start_mvu, 0);
    chk("zero_no_write", dram_write_enable, 0);
    next();
    chk("zero_done_single", done, 0);
    chk("zero_ready", cmd_ready, 1);
    chk("zero_no_reset_mvu2", reset_mvu, 0);

    // Address wrap with a fifth spurious MFU pulse after the last row.
    run_job(4, 'h3FE, 1'b0, 2, 8);

    // Stray done_mvm while idle.
    done_mvm = 1'b1;
    #1;
    next();
    done_mvm = 1'b0;
    chk("stray_done_mvm_idle", outv(), 9'b1_0000_0000);

    // Reset during DRAIN at ic=2.
    cmd_valid  = 1'b1;
    cmd_rows   = 5'd8;
    cmd_base   = 10'h040;
    cmd_bypass = 1'b0;
    next();
    cmd_valid = 1'b0;
    next();
    repeat (3) next();
    done_mvm = 1'b1;
    next();
    done_mvm = 1'b0;
    next();
    next();
    chk("midjob_ic2_addr", orf_rd_addr, 2);
    chk("midjob_ic2_ida", in_data_available, 1);
    reset = 1'b1;
    next();
    chk("midjob_reset_outputs", outv(), 9'b1_0000_0000);
    chk("midjob_reset_orf", orf_rd_addr, 0);
    reset = 1'b0;
    next();
    chk("midjob_no_done", outv(), 9'b1_0000_0000);
    run_job(3, 'h200, 1'b1, 4, 0);

    // Watchdog: done_mvm never arrives.
    cmd_valid  = 1'b1;
    cmd_rows   = 5'd2;
    cmd_base   = 10'h000;
    cmd_bypass = 1'b0;
    next();
    cmd_valid = 1'b0;
    next();
    chk("wd_start_mvu", start_mvu, 1);
    k   = -1;
    got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        k   = i;
        chk("wd_err_at_done", err, 1);
      end else begin
        next();
      end
    end
    chk("wd_done_latency", k, 1024);
    next();
    chk("wd_back_idle", outv(), 9'b1_0000_0010);
    run_job(2, 'h010, 1'b1, 1, 0);
    chk("wd_err_sticky", err, 1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    chk("wd_err_cleared", err, 0);
    next();
    chk("final_idle", outv(), 9'b1_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
